// File: rtl/my_sum_seq_pkg.sv
// Shared definitions for the chunk-serial adder/subtractor: FSM states,
// counter sizing and the one-bit full-adder cell.
package my_sum_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The chunk counter needs at least one bit even when a single chunk covers the word.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Full-adder cell, returns {carry, sum}.
   function automatic logic [1:0] bitsum(input logic a, input logic b, input logic c);
      return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction

endpackage

// File: rtl/my_sum_seq_if.sv
// Request/result bundle of my_sum_seq; the requester is the master.
interface my_sum_seq_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] Ain;
   logic [WIDTH-1:0] Bin;
   logic             Ci;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Sout;
   logic             Co;
   logic             Ov;

   modport master (output start, sub, Ain, Bin, Ci,
                   input  busy, done, Sout, Co, Ov);
   modport slave  (input  start, sub, Ain, Bin, Ci,
                   output busy, done, Sout, Co, Ov);
endinterface

// File: rtl/my_sum_seq_chunk.sv
// CHUNK-bit combinational ripple adder built from full-adder cells; also
// exports the carry into its MSB so the caller can form signed overflow.
module my_sum_chunk
   import my_sum_seq_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] Ain,
   input  logic [CHUNK-1:0] Bin,
   input  logic             Ci,
   output logic [CHUNK-1:0] Sout,
   output logic             Co,
   output logic             Cmsb
);

   logic [CHUNK:0] c;

   assign c[0] = Ci;

   for (genvar i = 0; i < CHUNK; i++) begin : g_cell
      assign {c[i+1], Sout[i]} = bitsum(Ain[i], Bin[i], c[i]);
   end

   assign Co   = c[CHUNK];
   assign Cmsb = c[CHUNK-1];

endmodule

// File: rtl/my_sum_seq.sv
// Chunk-serial adder/subtractor: captures operands on start, adds CHUNK bits
// per clock through one small ripple adder, then publishes Sout/Co/Ov with a done pulse.
module my_sum_seq
   import my_sum_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic         clk,
   input logic         rst,
   my_sum_seq_if.slave bus
);

   localparam int N     = WIDTH / CHUNK;
   localparam int CNT_W = cnt_width(N);

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic [CHUNK-1:0] csum;
   logic             cout;
   logic             cmsb;
   logic [WIDTH-1:0] acc_next;
   logic             last;

   // Operands shift right each cycle so the adder always sees the low chunk.
   my_sum_chunk #(.CHUNK(CHUNK)) u_chunk (
      .Ain  (a_r[CHUNK-1:0]),
      .Bin  (b_r[CHUNK-1:0]),
      .Ci   (carry),
      .Sout (csum),
      .Co   (cout),
      .Cmsb (cmsb)
   );

   // Sum chunks enter at the top of acc, so after N steps chunk 0 sits at bit 0.
   assign acc_next = (acc >> CHUNK) | (WIDTH'(csum) << (WIDTH - CHUNK));
   assign last     = (cnt == CNT_W'(N - 1));

   // NOTE: all state here uses <= so every register sees pre-edge values;
   // a blocking = would let later statements observe already-updated state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_r      <= '0;
         b_r      <= '0;
         acc      <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.Sout <= '0;
         bus.Co   <= 1'b0;
         bus.Ov   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  // Subtract as A + ~B + 1.
                  a_r      <= bus.Ain;
                  b_r      <= bus.sub ? ~bus.Bin : bus.Bin;
                  carry    <= bus.sub | bus.Ci;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_r   <= a_r >> CHUNK;
               b_r   <= b_r >> CHUNK;
               acc   <= acc_next;
               carry <= cout;
               cnt   <= cnt + CNT_W'(1);
               if (last) begin
                  bus.Sout <= acc_next;
                  bus.Co   <= cout;
                  bus.Ov   <= cout ^ cmsb;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  state    <= DONE;
               end
            end
            default: begin
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
